// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory port controller: size codes,
// FSM states, requester ids and the request legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    // oor: word index is beyond the memory depth
    function automatic logic is_illegal(input logic [1:0] size,
                                        input logic [1:0] a_lo,
                                        input logic       oor);
        case (size)
            SZ_B:    is_illegal = oor;
            SZ_H:    is_illegal = oor | a_lo[0];
            SZ_W:    is_illegal = oor | (|a_lo);
            default: is_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_port_ctrl_if.sv
// One requester port of the data-memory controller (core or loader).
interface dmem_port_ctrl_if #(parameter int AW = 32);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          unsgn;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          done;
    logic          err;

    modport master (output req, we, size, unsgn, addr, wdata,
                    input  rdata, done, err);
    modport slave  (input  req, we, size, unsgn, addr, wdata,
                    output rdata, done, err);
endinterface

// File: rtl/dmem_lane_unit.sv
// Byte/half lane handling on a 32-bit memory word: load extract with sign or
// zero extension, and lane merge of store data for read-modify-write.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  a_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] ld_o,
    output logic [31:0] merge_o
);
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        bsh    = {a_lo_i, 3'b000};
        hsh    = {a_lo_i[1], 4'b0000};
        byte_v = word_i[bsh +: 8];
        half_v = word_i[hsh +: 16];
        case (size_i)
            SZ_B:    ld_o = {{24{~uns_i & byte_v[7]}}, byte_v};
            SZ_H:    ld_o = {{16{~uns_i & half_v[15]}}, half_v};
            default: ld_o = word_i;
        endcase
        merge_o = word_i;
        if (size_i == SZ_B)
            merge_o[bsh +: 8] = wdata_i[7:0];
        else if (size_i == SZ_H)
            merge_o[hsh +: 16] = wdata_i;
    end
endmodule

// File: rtl/dmem_port_ctrl.sv
// Two-requester controller for a 32-bit word memory: round-robin arbitration,
// byte/half/word loads and stores, read-modify-write for sub-word stores.
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_port_ctrl_if.slave   c_if,
    dmem_port_ctrl_if.slave   l_if,
    output logic [31:0]       mem_a_o,
    output logic [31:0]       mem_wd_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rd_i
);
    localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          port_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merge_q;

    logic          any_req, win;
    logic          sel_we, sel_uns, oor, illegal;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [31:0]   ld_data, merge_data, rdata;
    logic          done, err;

    // Tie goes to whichever port was not granted last; a lone requester wins.
    always_comb begin
        any_req   = c_if.req | l_if.req;
        win       = (c_if.req && l_if.req) ? ~last_gnt_q : l_if.req;
        sel_we    = win ? l_if.we    : c_if.we;
        sel_size  = win ? l_if.size  : c_if.size;
        sel_uns   = win ? l_if.unsgn : c_if.unsgn;
        sel_addr  = win ? l_if.addr  : c_if.addr;
        sel_wdata = win ? l_if.wdata : c_if.wdata;
        oor       = {2'b00, sel_addr[AW-1:2]} >= DEPTH_L;
        illegal   = is_illegal(sel_size, sel_addr[1:0], oor);
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            S_IDLE: if (any_req) begin
                last_gnt_d = win;
                if (illegal)                state_d = S_ERR;
                else if (!sel_we)           state_d = S_LOAD;
                else if (sel_size == SZ_W)  state_d = S_STORE;
                else                        state_d = S_RMW_RD;
            end
            S_RMW_RD: state_d = S_RMW_WR;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= PORT_L;
            port_q     <= PORT_C;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            if (state_q == S_IDLE && any_req) begin
                port_q  <= win;
                we_q    <= sel_we;
                size_q  <= sel_size;
                uns_q   <= sel_uns;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == S_RMW_RD)
                merge_q <= merge_data;
        end
    end

    dmem_lane_unit u_lane (
        .word_i  (mem_rd_i),
        .a_lo_i  (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q[15:0]),
        .ld_o    (ld_data),
        .merge_o (merge_data)
    );

    // Everything below decodes from registered state, never from *_req.
    always_comb begin
        mem_we_o = 1'b0;
        mem_wd_o = '0;
        done     = 1'b0;
        err      = 1'b0;
        rdata    = '0;
        case (state_q)
            S_LOAD:   begin done = 1'b1; rdata = ld_data; end
            S_STORE:  begin done = 1'b1; mem_we_o = we_q; mem_wd_o = wdata_q; end
            S_RMW_WR: begin done = 1'b1; mem_we_o = we_q; mem_wd_o = merge_q; end
            S_ERR:    begin done = 1'b1; err = 1'b1; end
            default:  ;
        endcase
    end

    assign mem_a_o    = 32'({addr_q[AW-1:2], 2'b00});
    assign c_if.done  = done & (port_q == PORT_C);
    assign c_if.err   = err  & (port_q == PORT_C);
    assign c_if.rdata = (port_q == PORT_C) ? rdata : 32'h0;
    assign l_if.done  = done & (port_q == PORT_L);
    assign l_if.err   = err  & (port_q == PORT_L);
    assign l_if.rdata = (port_q == PORT_L) ? rdata : 32'h0;
endmodule
